// File: rtl/buttons_debounce_pkg.sv
// Shared constants and types for the buttons_debounce block.
//   NUM_BUTTONS / NUM_SWITCHES : channel counts
//   DEF_*                      : default timing parameters (cycles at 27 MHz)
package buttons_debounce_pkg;

  localparam int unsigned NUM_BUTTONS  = 4;
  localparam int unsigned NUM_SWITCHES = 4;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 270000;   // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 13500000; // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 2700000;  // 100 ms

  typedef logic [NUM_BUTTONS-1:0]  btn_vec_t;
  typedef logic [NUM_SWITCHES-1:0] sw_vec_t;

endpackage : buttons_debounce_pkg

// File: rtl/buttons_debounce_if.sv
// Signal bundle between the board I/O side and the debouncer.
//   buttons, switches     : raw asynchronous levels (driven by master)
//   buttons_o, switches_o : debounced levels (driven by slave)
//   press_o, release_o    : one-cycle button event pulses (driven by slave)
interface buttons_debounce_if;
  import buttons_debounce_pkg::*;

  btn_vec_t buttons;
  sw_vec_t  switches;
  btn_vec_t buttons_o;
  sw_vec_t  switches_o;
  btn_vec_t press_o;
  btn_vec_t release_o;

  modport master (
    output buttons, switches,
    input  buttons_o, switches_o, press_o, release_o
  );

  modport slave (
    input  buttons, switches,
    output buttons_o, switches_o, press_o, release_o
  );

endinterface : buttons_debounce_if

// File: rtl/buttons_debounce_ch.sv
// Single debounce channel: 2-flop synchronizer, stability counter, stable
// level q, registered output level and edge pulses.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_raw        : raw asynchronous input
//   i_rpt_c      : extra press request (auto-repeat), registered into o_rise
//   o_level      : debounced level
//   o_rise/o_fall: one-cycle pulses in the first cycle o_level changes
//                  (forced 0 when IS_BUTTON is 0)
module debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter bit          IS_BUTTON       = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_rpt_c,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned       CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  // Synchronize, count disagreement cycles, then register level and edges.
  // o_level lags q by one cycle so the pulse lines up with the new level.
  // Repeat requests are gated by q so a press never lands on a release cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_q     <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_q) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_q   <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_level <= r_q;
      r_rise  <= IS_BUTTON & ((r_q & ~r_level) | (r_q & i_rpt_c));
      r_fall  <= IS_BUTTON & (~r_q & r_level);
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule : debounce_ch

// File: rtl/buttons_debounce.sv
// Debouncer for 4 push buttons and 4 slide switches with optional
// button auto-repeat.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : buttons_debounce_if slave (raw inputs in, debounced
//                  levels and press/release pulses out)
// Optional feature macro: BTN_AUTOREPEAT_EN adds per-button repeat counters.
module buttons_debounce
  import buttons_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk_i,
  input  logic               rst_i,
  buttons_debounce_if.slave  bus
);

  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  btn_vec_t w_btn_level;
  btn_vec_t w_press;
  btn_vec_t w_release;
  btn_vec_t w_rpt_c;
  sw_vec_t  w_sw_level;
  sw_vec_t  w_sw_rise_unused;
  sw_vec_t  w_sw_fall_unused;

  // Button channels.
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IS_BUTTON       (1'b1)
    ) u_ch (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_raw   (bus.buttons[i]),
      .i_rpt_c (w_rpt_c[i]),
      .o_level (w_btn_level[i]),
      .o_rise  (w_press[i]),
      .o_fall  (w_release[i])
    );
  end

  // Switch channels: level only, pulses tied off inside the channel.
  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
    debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IS_BUTTON       (1'b0)
    ) u_ch (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_raw   (bus.switches[i]),
      .i_rpt_c (1'b0),
      .o_level (w_sw_level[i]),
      .o_rise  (w_sw_rise_unused[i]),
      .o_fall  (w_sw_fall_unused[i])
    );
  end

`ifdef BTN_AUTOREPEAT_EN
  logic [RPT_W-1:0] r_rpt_cnt [NUM_BUTTONS];
  btn_vec_t         r_rpt_active;
  btn_vec_t         r_rpt_first;

  // r_rpt_cnt holds cycles elapsed since the last press pulse; fire one
  // cycle early so the channel's register lands exactly on the interval.
  always_comb begin
    w_rpt_c = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_rpt_c[i] = w_btn_level[i] & r_rpt_active[i] &
                   (r_rpt_cnt[i] == (r_rpt_first[i] ? RPT_W'(REPEAT_DELAY - 1)
                                                    : RPT_W'(REPEAT_PERIOD - 1)));
    end
  end

  // Arm on the first cycle the level is high (the press pulse cycle).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rpt_active <= '0;
      r_rpt_first  <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) r_rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (!w_btn_level[i]) begin
          r_rpt_active[i] <= 1'b0;
          r_rpt_first[i]  <= 1'b0;
          r_rpt_cnt[i]    <= '0;
        end else if (!r_rpt_active[i]) begin
          r_rpt_active[i] <= 1'b1;
          r_rpt_first[i]  <= 1'b1;
          r_rpt_cnt[i]    <= RPT_W'(1);
        end else if (w_rpt_c[i]) begin
          r_rpt_first[i]  <= 1'b0;
          r_rpt_cnt[i]    <= '0;
        end else begin
          r_rpt_cnt[i]    <= r_rpt_cnt[i] + RPT_W'(1);
        end
      end
    end
  end
`else
  logic [RPT_W-1:0] w_rpt_unused;
  assign w_rpt_unused = '0;
  assign w_rpt_c      = '0;
`endif

  assign bus.buttons_o  = w_btn_level;
  assign bus.switches_o = w_sw_level;
  assign bus.press_o    = w_press;
  assign bus.release_o  = w_release;

endmodule : buttons_debounce

// File: doc/buttons_debounce.md
BUTTONS_DEBOUNCE -- requirements
Module: buttons_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 270000, sets cycles a synchronized input must differ from its stable level before the stable level updates (10 ms at 27 MHz); legal range 2 to 2^20.
REQ-002 Parameter REPEAT_DELAY, default 13500000, sets cycles from a debounced press to the first auto-repeat pulse; used only with BTN_AUTOREPEAT_EN.
REQ-003 Parameter REPEAT_PERIOD, default 2700000, sets cycles between subsequent auto-repeat pulses; used only with BTN_AUTOREPEAT_EN.
REQ-004 clk_i  input  1  single system clock; every flop samples its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 buttons  input  4  raw asynchronous push-button levels, 1 = pressed.
REQ-007 switches  input  4  raw asynchronous slide-switch levels.
REQ-008 buttons_o  output  4  debounced button levels.
REQ-009 switches_o  output  4  debounced switch levels.
REQ-010 press_o  output  4  one-cycle pulse per button on a debounced 0->1 transition, plus auto-repeat pulses when enabled.
REQ-011 release_o  output  4  one-cycle pulse per button on a debounced 1->0 transition.

Function
REQ-012 Each of the 8 inputs (4 buttons, 4 switches) shall pass through a two-flop synchronizer before any other logic.
REQ-013 Each channel shall hold a stable level q and a counter cnt wide enough for DEBOUNCE_CYCLES-1.
REQ-014 Synchronized value equal to q: cnt shall be cleared to 0.
REQ-015 Synchronized value differing from q and cnt < DEBOUNCE_CYCLES-1: cnt shall increment by 1.
REQ-016 Synchronized value differing from q and cnt == DEBOUNCE_CYCLES-1: q shall take the synchronized value and cnt shall clear to 0 in the same cycle.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall restart the count and never change q.
REQ-018 A raw input change held stable shall appear on buttons_o/switches_o exactly DEBOUNCE_CYCLES+2 clock edges after the first edge that samples it.
REQ-019 press_o[i] and release_o[i] shall be registered and high for exactly one cycle, in the first cycle buttons_o[i] shows its new value.
REQ-020 press_o and release_o of one channel shall never be high in the same cycle; channels shall operate fully independently and simultaneously.
REQ-021 Switch channels shall generate no pulses.

Reset
REQ-022 While rst_i is high at a clock edge, all synchronizer flops, q, cnt, repeat counters, buttons_o, switches_o, press_o and release_o shall become 0.
REQ-023 Deasserting reset with an input held at 1 shall yield a normal debounced 0->1 transition, including press_o, DEBOUNCE_CYCLES+2 edges later.
REQ-024 Reset asserted mid-count or mid-repeat shall abandon the operation with no pulse emitted.

Configuration
REQ-025 Macro BTN_AUTOREPEAT_EN defined: while buttons_o[i] stays 1, press_o[i] shall pulse REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles; release shall clear the repeat counter immediately.
REQ-026 Macro BTN_AUTOREPEAT_EN undefined: no repeat counters shall be instantiated; press_o shall pulse only on debounced 0->1 transitions.

Structure
REQ-027 A shared package shall hold NUM_BUTTONS=4, NUM_SWITCHES=4, and the default values of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD.
REQ-028 One sub-module, debounce_ch, shall implement a single channel (synchronizer, counter, q, edge pulses); the top shall instantiate it 8 times and add repeat logic to button channels.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 buttons=0001 held from edge 0 -> buttons_o[0]=1 and press_o=0001 for one cycle at edge 6; other outputs unchanged.
REQ-030 buttons[1] 1 for 3 cycles then 0 -> buttons_o and press_o remain 0 throughout.
REQ-031 buttons[2] pressed to stable, then released -> release_o=0100 for one cycle at 6 edges after release; press_o[2]=0 that cycle.
REQ-032 switches=1010 held -> switches_o=1010 at edge 6; press_o and release_o stay 0000.
REQ-033 BTN_AUTOREPEAT_EN defined, buttons[3] held 30 cycles after debounce -> press_o[3] pulses at +0, +10, +13, +16, ...; stops on release.
REQ-034 rst_i asserted for one cycle 2 edges into a 4-cycle count -> all outputs 0, no pulse, new count starts after reset.
